pixel_write_queue: RTL and testbench

Receives the pixel plot stream (x, y, colour, plot strobe) from the game control path and writes it into the 320x240 12-bit frame buffer. It buffers bursts of plot requests in a small FIFO and converts each accepted pixel to a linear frame-buffer address (y*320 + x). It drives a write strobe that the memory can stall. It sits between the control path's VGA-facing outputs and the frame-buffer write port, and lets drawing FSMs plot one pixel per cycle while the memory side is busy.

---
 rtl/pixel_write_queue.sv | 130 +++++++++++++
 tb/tb_pixel_write_queue.sv | 236 +++++++++++++++++++++++
 2 files changed

// File: rtl/pixel_write_queue.sv
// Plot-stream to frame-buffer writer: range check, FIFO buffering, y*H_RES+x addressing.
// Latency: plot at edge N -> fb_we with address after edge N+1; 1 pixel/cycle sustained.
// Backpressure: fb_busy holds the output register; ready drops at DEPTH queued; rejects are counted.

module fifo #(
  parameter int W     = 8,
  parameter int DEPTH = 8
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     push,
  input  logic [W-1:0]             wr_dat,
  input  logic                     pop,
  output logic [W-1:0]             rd_dat,
  output logic [$clog2(DEPTH):0]   level
);
  localparam int AW = $clog2(DEPTH);
  localparam int LW = AW + 1;

  logic [W-1:0]  mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;

  // The caller never pushes when full or pops when empty.
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop)  rd_ptr <= rd_ptr + AW'(1);
      level <= level + LW'(push) - LW'(pop);
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= wr_dat;
  end

  assign rd_dat = mem[rd_ptr];
endmodule

module pixel_write_queue #(
  parameter int DEPTH = 8,
  parameter int H_RES = 320,
  parameter int V_RES = 240
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [8:0]               x,
  input  logic [7:0]               y,
  input  logic [11:0]              c,
  input  logic                     plot,
  output logic                     ready,
  output logic [16:0]              fb_addr,
  output logic [11:0]              fb_data,
  output logic                     fb_we,
  input  logic                     fb_busy,
  output logic [$clog2(DEPTH):0]   level,
  output logic [7:0]               ovf_count,
  output logic [7:0]               oob_count
);
  localparam int LW = $clog2(DEPTH) + 1;

  typedef struct packed {
    logic [8:0]  x;
    logic [7:0]  y;
    logic [11:0] c;
  } pix_t;

  pix_t        in_pix;
  pix_t        head_pix;
  logic        in_range;
  logic        full;
  logic        push;
  logic        pop;
  logic        out_free;
  logic [16:0] head_addr;

  assign in_pix   = '{x: x, y: y, c: c};
  assign in_range = (x < 9'(H_RES)) && (y < 8'(V_RES));
  assign full     = (level == LW'(DEPTH));
  assign ready    = !full;
  // Full is judged on the registered level, so a same-cycle pop never admits a push.
  assign push     = plot && in_range && !full;
  assign out_free = !fb_we || !fb_busy;
  assign pop      = out_free && (level != '0);
  assign head_addr = 17'(head_pix.y) * 17'(H_RES) + 17'(head_pix.x);

  fifo #(
    .W     ($bits(pix_t)),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk    (clk),
    .reset  (reset),
    .push   (push),
    .wr_dat (in_pix),
    .pop    (pop),
    .rd_dat (head_pix),
    .level  (level)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      fb_we   <= 1'b0;
      fb_addr <= '0;
      fb_data <= '0;
    end else if (out_free) begin
      fb_we <= pop;
      if (pop) begin
        fb_addr <= head_addr;
        fb_data <= head_pix.c;
      end
    end
  end

  // Range rejects take priority, so a pixel lands in at most one counter.
  always_ff @(posedge clk) begin
    if (reset) begin
      ovf_count <= '0;
      oob_count <= '0;
    end else begin
      if (plot && !in_range && oob_count != 8'hFF)
        oob_count <= oob_count + 8'd1;
      if (plot && in_range && full && ovf_count != 8'hFF)
        ovf_count <= ovf_count + 8'd1;
    end
  end
endmodule

// File: tb/tb_pixel_write_queue.sv
// Directed bench for pixel_write_queue: vector table for single pixels plus multi-cycle sequences.
module tb_pixel_write_queue;
  localparam int DEPTH = 8;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [8:0]  x = '0;
  logic [7:0]  y = '0;
  logic [11:0] c = '0;
  logic        plot = 1'b0;
  logic        ready;
  logic [16:0] fb_addr;
  logic [11:0] fb_data;
  logic        fb_we;
  logic        fb_busy = 1'b0;
  logic [3:0]  level;
  logic [7:0]  ovf_count;
  logic [7:0]  oob_count;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  pixel_write_queue #(.DEPTH(DEPTH), .H_RES(320), .V_RES(240)) dut (
    .clk       (clk),
    .reset     (reset),
    .x         (x),
    .y         (y),
    .c         (c),
    .plot      (plot),
    .ready     (ready),
    .fb_addr   (fb_addr),
    .fb_data   (fb_data),
    .fb_we     (fb_we),
    .fb_busy   (fb_busy),
    .level     (level),
    .ovf_count (ovf_count),
    .oob_count (oob_count)
  );

  typedef struct {
    logic [8:0]  x;
    logic [7:0]  y;
    logic [11:0] c;
    bit          valid;
    logic [16:0] addr;
  } vec_t;

  vec_t vecs[9];

  logic [28:0] got_q[$];
  logic [28:0] exp_q[$];

  // A write is accepted at the next rising edge when fb_we=1 and fb_busy=0.
  always @(negedge clk) begin
    if (!reset && fb_we && !fb_busy) got_q.push_back({fb_addr, fb_data});
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset(input int n);
    reset   = 1'b1;
    plot    = 1'b0;
    fb_busy = 1'b0;
    repeat (n) tick();
    reset = 1'b0;
    got_q.delete();
    exp_q.delete();
  endtask

  function automatic logic [16:0] addr_of(input int px, input int py);
    return 17'(py * 320 + px);
  endfunction

  task automatic set_pix(input int px, input int py, input int pc);
    x = 9'(px);
    y = 8'(py);
    c = 12'(pc);
  endtask

  task automatic compare_q(input string name);
    chk({name, "_count"}, got_q.size(), exp_q.size());
    for (int i = 0; i < got_q.size() && i < exp_q.size(); i++)
      chk({name, "_write"}, {3'b0, got_q[i]}, {3'b0, exp_q[i]});
    got_q.delete();
    exp_q.delete();
  endtask

  initial begin
    int oob_exp;
    int idx;
    int cyc;

    vecs[0] = '{x: 9'd5,   y: 8'd2,   c: 12'hF00, valid: 1'b1, addr: 17'd645};
    vecs[1] = '{x: 9'd319, y: 8'd239, c: 12'h0AB, valid: 1'b1, addr: 17'd76799};
    vecs[2] = '{x: 9'd320, y: 8'd0,   c: 12'hFFF, valid: 1'b0, addr: 17'd0};
    vecs[3] = '{x: 9'd0,   y: 8'd240, c: 12'hFFF, valid: 1'b0, addr: 17'd0};
    vecs[4] = '{x: 9'd0,   y: 8'd0,   c: 12'h123, valid: 1'b1, addr: 17'd0};
    vecs[5] = '{x: 9'd100, y: 8'd100, c: 12'h456, valid: 1'b1, addr: 17'd32100};
    vecs[6] = '{x: 9'd511, y: 8'd255, c: 12'h789, valid: 1'b0, addr: 17'd0};
    vecs[7] = '{x: 9'd319, y: 8'd0,   c: 12'h00F, valid: 1'b1, addr: 17'd319};
    vecs[8] = '{x: 9'd0,   y: 8'd239, c: 12'h0F0, valid: 1'b1, addr: 17'd76480};

    // Reset and idle
    repeat (2) tick();
    chk("rst_we", fb_we, 0);
    chk("rst_addr", fb_addr, 0);
    chk("rst_data", fb_data, 0);
    chk("rst_level", level, 0);
    chk("rst_ready", ready, 1);
    chk("rst_ovf", ovf_count, 0);
    chk("rst_oob", oob_count, 0);
    reset = 1'b0;
    tick();

    // Single pixels, idle memory
    oob_exp = 0;
    for (int i = 0; i < 9; i++) begin
      set_pix(vecs[i].x, vecs[i].y, vecs[i].c);
      plot = 1'b1;
      tick();
      plot = 1'b0;
      if (!vecs[i].valid) oob_exp++;
      chk("vec_level", level, vecs[i].valid ? 1 : 0);
      chk("vec_oob", oob_count, oob_exp);
      chk("vec_we_n1", fb_we, 0);
      tick();
      chk("vec_we_n2", fb_we, vecs[i].valid);
      if (vecs[i].valid) begin
        chk("vec_addr", fb_addr, vecs[i].addr);
        chk("vec_data", fb_data, vecs[i].c);
      end
      tick();
      chk("vec_we_n3", fb_we, 0);
      chk("vec_level_end", level, 0);
    end
    chk("vec_ovf", ovf_count, 0);
    got_q.delete();

    // Backpressure and overflow
    do_reset(1);
    fb_busy = 1'b1;
    for (int i = 0; i < 12; i++) begin
      set_pix(10 + i, i, 12'h100 + i);
      plot = 1'b1;
      if (i < 9) exp_q.push_back({addr_of(10 + i, i), 12'(12'h100 + i)});
      tick();
    end
    plot = 1'b0;
    chk("bp_level", level, 8);
    chk("bp_ready", ready, 0);
    chk("bp_ovf", ovf_count, 3);
    chk("bp_oob", oob_count, 0);
    chk("bp_we", fb_we, 1);
    chk("bp_addr", fb_addr, addr_of(10, 0));
    tick();
    chk("bp_hold_we", fb_we, 1);
    chk("bp_hold_addr", fb_addr, addr_of(10, 0));
    chk("bp_hold_data", fb_data, 12'h100);
    fb_busy = 1'b0;
    repeat (9) tick();
    chk("bp_drain_we", fb_we, 0);
    chk("bp_drain_level", level, 0);
    compare_q("bp");

    // Wrap-around with toggling stall, plot gated by ready
    do_reset(1);
    idx = 0;
    cyc = 0;
    while (!(idx == 40 && got_q.size() == 40) && cyc < 600) begin
      fb_busy = ((cyc / 3) % 2) == 1;
      if (idx < 40 && ready) begin
        set_pix((idx * 37) % 320, (idx * 13) % 240, idx * 97);
        exp_q.push_back({addr_of((idx * 37) % 320, (idx * 13) % 240), 12'(idx * 97)});
        plot = 1'b1;
        idx++;
      end else begin
        plot = 1'b0;
      end
      tick();
      cyc++;
    end
    plot = 1'b0;
    fb_busy = 1'b0;
    chk("wrap_timeout", cyc < 600, 1);
    chk("wrap_ovf", ovf_count, 0);
    compare_q("wrap");

    // Reset mid-stream
    do_reset(1);
    fb_busy = 1'b1;
    for (int i = 0; i < 6; i++) begin
      set_pix(i, 7, i);
      plot = 1'b1;
      tick();
    end
    plot = 1'b0;
    chk("mid_level", level, 5);
    chk("mid_we", fb_we, 1);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    chk("mid_rst_we", fb_we, 0);
    chk("mid_rst_level", level, 0);
    chk("mid_rst_ready", ready, 1);
    chk("mid_rst_addr", fb_addr, 0);
    fb_busy = 1'b0;
    repeat (20) tick();
    chk("mid_no_stale", got_q.size(), 0);

    // Saturating out-of-range counter
    do_reset(1);
    set_pix(400, 0, 0);
    plot = 1'b1;
    repeat (260) tick();
    plot = 1'b0;
    chk("sat_oob", oob_count, 255);
    chk("sat_ovf", ovf_count, 0);
    chk("sat_level", level, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
